// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad entry controller: key value constants,
// debounce and entry state encodings, and default timing parameters.
package keypad_pkg;

   localparam logic [3:0] KEY_ENTER = 4'hF;
   localparam logic [3:0] KEY_BKSP  = 4'hE;
   localparam logic [3:0] KEY_CLR   = 4'hC;
   localparam logic [3:0] KEY_FA    = 4'hA;
   localparam logic [3:0] KEY_FB    = 4'hB;
   localparam logic [3:0] KEY_FD    = 4'hD;

   // ~8 ms at 25.175 MHz (two scan periods) and ~5 s of inactivity
   localparam int unsigned DEF_DEBOUNCE_CYC = 201400;
   localparam int unsigned DEF_TIMEOUT_CYC  = 125875000;

   typedef enum logic [1:0] {
      DB_WAIT_PRESS,
      DB_PRESS,
      DB_HELD,
      DB_REL
   } db_state_e;

   typedef enum logic [1:0] {
      ENT_EMPTY,
      ENT_EDIT,
      ENT_DONE
   } entry_state_e;

   function automatic logic is_digit(input logic [3:0] val);
      return (val <= 4'd9);
   endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Debounces the raw scanner code into single key events. One event per
// press; other keys are ignored while held (no rollover, no auto-repeat).
// key_evt is a one-cycle strobe raised DEBOUNCE_CYC cycles after a code
// first appears and stays stable.
module keypad_debounce
   import keypad_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] key_in,
   output logic       key_evt,
   output logic [3:0] key_val
);

   localparam int unsigned CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

   db_state_e       state, state_nxt;
   logic [4:0]      cand, cand_nxt;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic            at_end;

   assign at_end  = (cnt == CW'(DEBOUNCE_CYC - 1));
   assign key_val = cand[3:0];

   // State, candidate code and stability counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= DB_WAIT_PRESS;
         cand  <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cand  <= cand_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next-state, counter control and event strobe
   always_comb begin
      state_nxt = state;
      cand_nxt  = cand;
      cnt_nxt   = cnt;
      key_evt   = 1'b0;
      unique case (state)
         DB_WAIT_PRESS: begin
            if (key_in[4]) begin
               cand_nxt  = key_in;
               cnt_nxt   = '0;
               state_nxt = DB_PRESS;
            end
         end
         DB_PRESS: begin
            if (!key_in[4]) begin
               cnt_nxt   = '0;
               state_nxt = DB_WAIT_PRESS;
            end else if (key_in != cand) begin
               cand_nxt = key_in;
               cnt_nxt  = '0;
            end else if (at_end) begin
               key_evt   = 1'b1;
               cnt_nxt   = '0;
               state_nxt = DB_HELD;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         DB_HELD: begin
            if (!key_in[4]) begin
               cnt_nxt   = '0;
               state_nxt = DB_REL;
            end
         end
         DB_REL: begin
            if (key_in[4]) begin
               state_nxt = DB_HELD;
            end else if (at_end) begin
               cnt_nxt   = '0;
               state_nxt = DB_WAIT_PRESS;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         default: state_nxt = DB_WAIT_PRESS;
      endcase
   end

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Keypad entry controller: debounced key events are assembled into a
// multi-digit BCD entry with enter / backspace / clear editing, and function
// keys A, B, D are forwarded to the application.
// Optional feature macro: KEYPAD_TIMEOUT_EN (auto-clear of an idle EDIT entry).
module keypad_entry_ctrl
   import keypad_pkg::*;
#(
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
   parameter int unsigned TIMEOUT_CYC  = DEF_TIMEOUT_CYC
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4:0]              key_in,
   output logic [4*NUM_DIGITS-1:0] entry_bcd,
   output logic [3:0]              digit_cnt,
   output logic                    entry_done,
   output logic                    func_valid,
   output logic [3:0]              func_key,
   output logic                    overflow,
   output logic                    busy
);

   localparam int unsigned W = 4 * NUM_DIGITS;

   if (NUM_DIGITS < 1 || NUM_DIGITS > 8 || DEBOUNCE_CYC < 1 || TIMEOUT_CYC < 1) begin : g_param_check
      $error("keypad_entry_ctrl: parameter out of range");
   end

   entry_state_e  state, state_nxt;
   logic [W-1:0]  entry_q, entry_nxt;
   logic [3:0]    cnt_q, cnt_nxt;
   logic [3:0]    func_key_q, func_key_nxt;
   logic          done_nxt, func_valid_nxt, overflow_nxt;
   logic          key_evt;
   logic [3:0]    key_val;
   logic          timeout_hit;

   keypad_debounce #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC)
   ) u_deb (
      .clk     (clk),
      .rst     (rst),
      .key_in  (key_in),
      .key_evt (key_evt),
      .key_val (key_val)
   );

`ifdef KEYPAD_TIMEOUT_EN
   localparam int unsigned TCW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   logic [TCW-1:0] tcnt;

   assign timeout_hit = (state == ENT_EDIT) && !key_evt && (tcnt == TCW'(TIMEOUT_CYC - 1));

   // Inactivity counter: restarts on any key event, runs only while editing
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tcnt <= '0;
      end else if (key_evt || state != ENT_EDIT || timeout_hit) begin
         tcnt <= '0;
      end else begin
         tcnt <= tcnt + TCW'(1);
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   // Entry state, buffer and registered output pulses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ENT_EMPTY;
         entry_q    <= '0;
         cnt_q      <= '0;
         func_key_q <= '0;
         entry_done <= 1'b0;
         func_valid <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         state      <= state_nxt;
         entry_q    <= entry_nxt;
         cnt_q      <= cnt_nxt;
         func_key_q <= func_key_nxt;
         entry_done <= done_nxt;
         func_valid <= func_valid_nxt;
         overflow   <= overflow_nxt;
      end
   end

   // Key event decode: digit insertion, editing keys and function keys
   always_comb begin
      state_nxt      = state;
      entry_nxt      = entry_q;
      cnt_nxt        = cnt_q;
      func_key_nxt   = func_key_q;
      done_nxt       = 1'b0;
      func_valid_nxt = 1'b0;
      overflow_nxt   = 1'b0;
      if (key_evt) begin
         if (is_digit(key_val)) begin
            if (state != ENT_EDIT) begin
               entry_nxt = W'(key_val);
               cnt_nxt   = 4'd1;
               state_nxt = ENT_EDIT;
            end else if (cnt_q < 4'(NUM_DIGITS)) begin
               entry_nxt = (entry_q << 4) | W'(key_val);
               cnt_nxt   = cnt_q + 4'd1;
            end else begin
               overflow_nxt = 1'b1;
            end
         end else begin
            unique case (key_val)
               KEY_ENTER: begin
                  if (state == ENT_EDIT) begin
                     done_nxt  = 1'b1;
                     state_nxt = ENT_DONE;
                  end
               end
               KEY_BKSP: begin
                  if (state == ENT_EDIT) begin
                     entry_nxt = entry_q >> 4;
                     cnt_nxt   = cnt_q - 4'd1;
                     if (cnt_q == 4'd1) begin
                        state_nxt = ENT_EMPTY;
                     end
                  end
               end
               KEY_CLR: begin
                  entry_nxt = '0;
                  cnt_nxt   = '0;
                  state_nxt = ENT_EMPTY;
               end
               default: begin
                  // remaining non-digit codes are A, B and D
                  func_key_nxt   = key_val;
                  func_valid_nxt = 1'b1;
               end
            endcase
         end
      end else if (timeout_hit) begin
         entry_nxt = '0;
         cnt_nxt   = '0;
         state_nxt = ENT_EMPTY;
      end
   end

   assign entry_bcd = entry_q;
   assign digit_cnt = cnt_q;
   assign func_key  = func_key_q;
   assign busy      = (state == ENT_EDIT);

endmodule
